// File: rtl/ahb_si_resp_demux.sv
// AHB slave-interface response demux: routes one slave's response payload
// back to the master that owns the current data phase. Masters that request
// but are not granted are stalled; all others see an idle OKAY.
// Optional wait-state timeout is built when AHB_RESP_TIMEOUT_EN is defined.
module ahb_si_resp_demux #(
   parameter int CHANNEL_NUM    = 4,
   parameter int PAY_LOAD       = 34,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                            hclk,
   input  logic                            hreset,
   input  logic [CHANNEL_NUM-1:0]          grant,
   input  logic [CHANNEL_NUM*2-1:0]        htrans_m,
   input  logic [CHANNEL_NUM-1:0]          req,
   input  logic [PAY_LOAD-1:0]             payload_in,
   output logic [CHANNEL_NUM*PAY_LOAD-1:0] payload_out,
   output logic                            owner_vld,
   output logic [$clog2(CHANNEL_NUM)-1:0]  owner_idx
`ifdef AHB_RESP_TIMEOUT_EN
   ,
   output logic                            timeout_err
`endif
);

   localparam int IDX_W = $clog2(CHANNEL_NUM);

   logic                rdy;
   logic                act_any;
   logic [IDX_W-1:0]    act_idx;
   logic                hold_own;
   logic                drop_own;
   logic                ovr_en;
   logic [PAY_LOAD-1:0] ovr_pay;
   logic                unused_ok;

   assign rdy       = payload_in[PAY_LOAD-1];
   // Only HTRANS[1] matters (NONSEQ/SEQ); bit 0 is intentionally ignored.
   assign unused_ok = ^htrans_m;

   // Find the master starting an address phase (grant is one-hot or zero).
   always_comb begin
      act_any = 1'b0;
      act_idx = '0;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
         if (grant[i] && htrans_m[2*i+1]) begin
            act_any = 1'b1;
            act_idx = IDX_W'(i);
         end
      end
   end

`ifdef AHB_RESP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {TO_IDLE, TO_ERR1, TO_ERR2} to_state_t;

   to_state_t        to_state, to_state_nxt;
   logic [CNT_W-1:0] wait_cnt;

   // Count consecutive wait states seen by the current owner.
   always_ff @(posedge hclk) begin
      if (hreset || rdy || !owner_vld || to_state != TO_IDLE)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end

   // Timeout state register.
   always_ff @(posedge hclk) begin
      if (hreset)
         to_state <= TO_IDLE;
      else
         to_state <= to_state_nxt;
   end

   // Timeout next-state: fire a two-cycle ERROR after the wait limit.
   always_comb begin
      to_state_nxt = to_state;
      case (to_state)
         TO_IDLE: if (owner_vld && !rdy && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                     to_state_nxt = TO_ERR1;
         TO_ERR1: to_state_nxt = TO_ERR2;
         TO_ERR2: to_state_nxt = TO_IDLE;
         default: to_state_nxt = TO_IDLE;
      endcase
   end

   // Sticky timeout flag, set as the first ERROR cycle begins.
   always_ff @(posedge hclk) begin
      if (hreset)
         timeout_err <= 1'b0;
      else if (to_state == TO_IDLE && to_state_nxt == TO_ERR1)
         timeout_err <= 1'b1;
   end

   // Owner is frozen during the forced ERROR and dropped after its second cycle.
   assign hold_own = (to_state != TO_IDLE);
   assign drop_own = (to_state == TO_ERR2);
   assign ovr_en   = (to_state != TO_IDLE);

   // Forced ERROR payload: {0,1,0} then {1,1,0}.
   always_comb begin
      ovr_pay               = '0;
      ovr_pay[PAY_LOAD-1]   = (to_state == TO_ERR2);
      ovr_pay[PAY_LOAD-2]   = 1'b1;
   end
`else
   assign hold_own = 1'b0;
   assign drop_own = 1'b0;
   assign ovr_en   = 1'b0;
   assign ovr_pay  = '0;
`endif

   // Data-phase owner register; advances only when the slave is ready.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         owner_vld <= 1'b0;
         owner_idx <= '0;
      end else if (drop_own) begin
         owner_vld <= 1'b0;
      end else if (rdy && !hold_own) begin
         owner_vld <= act_any;
         if (act_any)
            owner_idx <= act_idx;
      end
   end

   // Per-master response routing; reset forces idle OKAY everywhere.
   always_comb begin
      logic [PAY_LOAD-1:0] slot;
      payload_out = '0;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
         slot = '0;
         if (hreset) begin
            slot[PAY_LOAD-1] = 1'b1;
         end else if (owner_vld && owner_idx == IDX_W'(i)) begin
            slot = ovr_en ? ovr_pay : payload_in;
         end else if (grant[i]) begin
            slot[PAY_LOAD-1] = rdy;
         end else if (req[i]) begin
            slot[PAY_LOAD-1] = 1'b0;
         end else begin
            slot[PAY_LOAD-1] = 1'b1;
         end
         payload_out[i*PAY_LOAD +: PAY_LOAD] = slot;
      end
   end

endmodule

// File: tb/tb_ahb_si_resp_demux.sv
// Self-checking bench for ahb_si_resp_demux: directed scenarios followed by
// randomized traffic checked against a behavioural ownership model.
module tb_ahb_si_resp_demux;

   localparam int N = 4;
   localparam int W = 34;
   localparam logic [W-1:0] IDLE_OK = {1'b1, 33'b0};

   logic             hclk = 1'b0;
   logic             hreset;
   logic [N-1:0]     grant;
   logic [2*N-1:0]   htrans_m;
   logic [N-1:0]     req;
   logic [W-1:0]     payload_in;
   logic [N*W-1:0]   payload_out;
   logic             owner_vld;
   logic [1:0]       owner_idx;
`ifdef AHB_RESP_TIMEOUT_EN
   logic             timeout_err;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model of the data-phase owner.
   bit       m_vld;
   logic [1:0] m_idx;

   ahb_si_resp_demux #(
      .CHANNEL_NUM(N),
      .PAY_LOAD(W),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .hclk(hclk),
      .hreset(hreset),
      .grant(grant),
      .htrans_m(htrans_m),
      .req(req),
      .payload_in(payload_in),
      .payload_out(payload_out),
      .owner_vld(owner_vld),
      .owner_idx(owner_idx)
`ifdef AHB_RESP_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   always #5 hclk = ~hclk;

   function automatic logic [W-1:0] po(input int i);
      return payload_out[i*W +: W];
   endfunction

   // What master i should see, from the routing rules.
   function automatic logic [W-1:0] exp_po(input int i);
      if (hreset)                   return IDLE_OK;
      if (m_vld && m_idx == 2'(i))  return payload_in;
      if (grant[i])                 return {payload_in[33], 33'b0};
      if (req[i])                   return '0;
      return IDLE_OK;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check every output against the model, mid-cycle.
   task automatic settle();
      @(negedge hclk);
      assert ($onehot0(grant)) else begin
         bad++;
         $error("FAIL grant_onehot observed=%b expected=onehot0", grant);
      end
      chk("owner_vld", owner_vld, m_vld);
      if (m_vld) chk("owner_idx", owner_idx, m_idx);
      for (int i = 0; i < N; i++) chk($sformatf("payload_out[%0d]", i), po(i), exp_po(i));
   endtask

   // Clock edge: advance the model with the inputs present at the edge.
   task automatic adv();
      @(posedge hclk);
      if (hreset) begin
         m_vld = 1'b0;
         m_idx = '0;
      end else if (payload_in[33]) begin
         m_vld = 1'b0;
         for (int i = 0; i < N; i++)
            if (grant[i] && htrans_m[2*i+1]) begin
               m_vld = 1'b1;
               m_idx = 2'(i);
            end
      end
      #1;
   endtask

   initial begin
      int  wcnt;
      int  g;
      bit  rdy;
      m_vld = 1'b0;
      m_idx = '0;
      hreset = 1'b1; grant = '0; htrans_m = '0; req = '0;
      payload_in = {1'b1, 1'b0, 32'h0BAD_0BAD};

      // Reset state.
      settle(); adv();
      settle();
      chk("reset_vld", owner_vld, 1'b0);
      chk("reset_idx", owner_idx, 2'd0);
      chk("reset_po0", po(0), IDLE_OK);
      adv();
      hreset = 1'b0;

      // Single read by master 0.
      grant = 4'b0001; htrans_m = 8'b0000_0010; payload_in = IDLE_OK;
      settle(); adv();
      grant = '0; htrans_m = '0; payload_in = {1'b1, 1'b0, 32'hDEAD_BEEF};
      settle();
      chk("single_po0", po(0), {1'b1, 1'b0, 32'hDEAD_BEEF});
      chk("single_idx", owner_idx, 2'd0);
      chk("single_vld", owner_vld, 1'b1);
      chk("single_po3", po(3), IDLE_OK);
      adv();

      // Wait states on owner 0 while master 2 requests.
      grant = 4'b0001; htrans_m = 8'b0000_0010; payload_in = IDLE_OK;
      settle(); adv();
      grant = '0; htrans_m = '0; req = 4'b0100; payload_in = {1'b0, 1'b0, 32'h1111_2222};
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("wait_po0_rdy", po(0) >> 33, 1'b0);
         chk("wait_po2_rdy", po(2) >> 33, 1'b0);
         chk("wait_idx", owner_idx, 2'd0);
         adv();
      end
      payload_in = {1'b1, 1'b0, 32'hCAFE_F00D};
      settle(); adv();
      req = '0;

      // Back-to-back: master 1 in data phase, master 3 takes over with no bubble.
      grant = 4'b0010; htrans_m = 8'b0000_1000; payload_in = IDLE_OK;
      settle(); adv();
      grant = 4'b1000; htrans_m = 8'b1000_0000; payload_in = {1'b1, 1'b0, 32'hAAAA_5555};
      settle();
      chk("b2b_po1", po(1), {1'b1, 1'b0, 32'hAAAA_5555});
      adv();
      grant = '0; htrans_m = '0; payload_in = {1'b1, 1'b0, 32'h1234_5678};
      settle();
      chk("b2b_idx", owner_idx, 2'd3);
      chk("b2b_po3", po(3), {1'b1, 1'b0, 32'h1234_5678});
      adv();

      // ERROR passthrough to owner 2.
      grant = 4'b0100; htrans_m = 8'b0010_0000; payload_in = IDLE_OK;
      settle(); adv();
      grant = '0; htrans_m = '0; payload_in = {1'b0, 1'b1, 32'h0BAD_F00D};
      settle();
      chk("err1_po2", po(2), {1'b0, 1'b1, 32'h0BAD_F00D});
      chk("err1_po0_resp", (po(0) >> 32) & 1, 1'b0);
      adv();
      payload_in = {1'b1, 1'b1, 32'h0BAD_F00D};
      settle();
      chk("err2_po2", po(2), {1'b1, 1'b1, 32'h0BAD_F00D});
      chk("err2_po1_resp", (po(1) >> 32) & 1, 1'b0);
      adv();
      payload_in = IDLE_OK;
      settle();
      chk("err_done_vld", owner_vld, 1'b0);
      adv();

      // Reset during a wait state.
      grant = 4'b0001; htrans_m = 8'b0000_0010;
      settle(); adv();
      grant = '0; htrans_m = '0; req = 4'b0110; payload_in = {1'b0, 1'b0, 32'h7777_7777};
      hreset = 1'b1;
      settle();
      for (int i = 0; i < N; i++) chk("rst_mid_po", po(i), IDLE_OK);
      adv();
      hreset = 1'b0; req = '0; payload_in = {1'b1, 1'b0, 32'h7777_7777};
      settle();
      chk("rst_mid_vld", owner_vld, 1'b0);
      chk("rst_mid_po0", po(0), IDLE_OK);
      adv();

      // Randomized traffic; wait runs kept short of the timeout limit.
      wcnt = 0;
      for (int n = 0; n < 400; n++) begin
         g = $urandom_range(0, N);
         grant = (g == N) ? '0 : 4'(1 << g);
         htrans_m = 8'($urandom);
         req = 4'($urandom);
         rdy = ($urandom_range(0, 9) < 7);
         if (wcnt >= 2) rdy = 1'b1;
         wcnt = rdy ? 0 : wcnt + 1;
         payload_in = {rdy, 1'($urandom), 32'($urandom)};
         hreset = ($urandom_range(0, 39) == 0);
         settle(); adv();
      end
      hreset = 1'b0;

`ifdef AHB_RESP_TIMEOUT_EN
      // Timeout: owner 1 with the slave stuck in wait states.
      hreset = 1'b1; grant = '0; htrans_m = '0; req = '0; payload_in = IDLE_OK;
      settle(); adv();
      hreset = 1'b0;
      grant = 4'b0010; htrans_m = 8'b0000_1000;
      settle(); adv();
      grant = '0; htrans_m = '0; payload_in = {1'b0, 1'b0, 32'h0000_0055};
      for (int k = 0; k < 4; k++) begin
         @(negedge hclk);
         chk("to_wait_po1", po(1), payload_in);
         @(posedge hclk); #1;
      end
      @(negedge hclk);
      chk("to_err1_po1", po(1), {1'b0, 1'b1, 32'h0});
      chk("to_err1_flag", timeout_err, 1'b1);
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("to_err2_po1", po(1), {1'b1, 1'b1, 32'h0});
      @(posedge hclk); #1;
      @(negedge hclk);
      chk("to_done_vld", owner_vld, 1'b0);
      chk("to_sticky", timeout_err, 1'b1);
      chk("to_done_po1", po(1), IDLE_OK);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_si_resp_demux.md
Name: ahb_si_resp_demux

Overview:
- Response-path partner of the slave-interface master mux in the AHB interconnect.
- For one slave port, it takes the slave's 34-bit response payload and returns it to the master that owns the current data phase.
- Masters that are requesting but not granted are stalled; all other masters see an idle OKAY.
- It tracks the data-phase owner across the AHB address/data pipeline, using the grant and HTRANS from the arbiter and master mux.

Parameters:
- CHANNEL_NUM, 4, number of masters that can reach this slave (≥2).
- PAY_LOAD, 34, response payload width, packed {hreadyout[33], hresp[32], hrdata[31:0]}.
- TIMEOUT_CYCLES, 16, wait-state limit used only with the optional feature (≥2).

Ports:
- hclk, input, 1, bus clock; all state updates on rising edge.
- hreset, input, 1, synchronous active-high reset.
- grant, input, CHANNEL_NUM, one-hot address-phase grant from the arbiter; all-zero means none.
- htrans_m, input, CHANNEL_NUM×2, HTRANS of each master.
- req, input, CHANNEL_NUM, per-master request for this slave.
- payload_in, input, PAY_LOAD, response payload from the slave.
- payload_out, output, CHANNEL_NUM×PAY_LOAD, per-master response payload, same packing.
- owner_vld, output, 1, a data phase is in progress.
- owner_idx, output, $clog2(CHANNEL_NUM), index of the data-phase owner.

Behaviour:
- Let rdy = payload_in[33], and let active(i) = grant[i] & htrans_m[i][1] (NONSEQ or SEQ).
- Owner register update, on every rising edge when rdy=1:
  - If some active(i): owner_idx←i, owner_vld←1.
  - Otherwise: owner_vld←0 and owner_idx holds.
- When rdy=0, owner_vld and owner_idx hold. The pipeline never advances while the slave inserts wait states.
- grant with more than one bit set is illegal. Behaviour is undefined and is flagged by a bench assertion.
- Output routing is combinational from the registered owner plus current inputs. For each master i, first matching rule wins:
  1. owner_vld & owner_idx==i: payload_out[i] = payload_in (full passthrough, including wait states and both ERROR cycles).
  2. grant[i]: hreadyout = rdy, hresp = 0, hrdata = 0. The address phase extends with the previous owner's data phase.
  3. req[i]: hreadyout = 0, hresp = 0, hrdata = 0 (stall until granted).
  4. Otherwise: hreadyout = 1, hresp = 0, hrdata = 0.
- A master that owns the data phase and is also granted the next address phase falls under rule 1. Rule 1 carries both phases, because the AHB HREADY is shared.
- Latency: 0 cycles for the response path; 1 registered pipeline stage for ownership.
- Reset:
  - owner_vld=0, owner_idx=0.
  - While hreset=1, all payload_out[i] are forced to {1,0,0}, overriding rules 1–3.
  - Reset in the middle of a transfer discards the data phase. No response is delivered after reset deasserts.
- A slave ERROR is passed through unchanged on both cycles. On the second cycle (rdy=1), a master that changes HTRANS to IDLE leaves owner_vld=0.
- Back-to-back transfers from different masters: owner_idx changes on the edge where the old data phase completes. There is no bubble.

Optional Feature:
- Macro: AHB_RESP_TIMEOUT_EN.
- Enabled:
  - An internal counter resets to 0 when rdy=1 or owner_vld=0, and increments while owner_vld & !rdy.
  - When the count reaches TIMEOUT_CYCLES, the block overrides the owner's payload with a two-cycle ERROR: cycle 1 {0,1,0}, cycle 2 {1,1,0}.
  - After cycle 2, owner_vld is cleared. The slave's payload is ignored for the owner until its rdy next returns to 1.
  - An extra output port, timeout_err (1 bit), is set sticky on the first ERROR cycle and cleared only by hreset.
- Disabled: no counter and no timeout_err port. Slave wait states are unbounded.

Test Plan:
- Single read: reset, then grant=0001, htrans_m[0]=NONSEQ, rdy=1. Next cycle, payload_in={1,0,0xDEADBEEF} → payload_out[0]={1,0,0xDEADBEEF}, owner_idx=0, owner_vld=1; the other three masters see {1,0,0}.
- Wait states with a stalled requester:
  - Stimulus: owner=0, slave holds rdy=0 for 3 cycles; req[2]=1, grant[2]=0.
  - Required: payload_out[0].hreadyout=0 for 3 cycles; payload_out[2].hreadyout=0; owner_idx stays 0.
- Back-to-back ownership:
  - Stimulus: master 1 in the data phase, master 3 granted with NONSEQ, rdy=1.
  - Required: next edge owner_idx=3; master 3's hrdata=0x12345678 is delivered in that cycle with no bubble.
- ERROR passthrough:
  - Stimulus: slave drives {0,1,x} then {1,1,x} to owner 2.
  - Required: master 2 sees both cycles unchanged; other masters see hresp=0 throughout.
- Reset mid-transfer: assert hreset during a wait state → owner_vld=0 next edge; all payload_out={1,0,0} while reset is asserted.
- Timeout (AHB_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: owner=1, slave holds rdy=0 indefinitely.
  - Required: after 4 wait cycles, master 1 sees {0,1,0} then {1,1,0}; timeout_err=1 sticky; owner_vld=0.
